// File: rtl/cache_port_arbiter_if.sv
// Shared req/gnt/rvalid memory port bundle.
// Used on both the master side and the cache side.
interface cache_port_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

  modport slave_ro (
    input  req, addr,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-master arbiter in front of the single cache port.
// One outstanding transaction; responses go to the owner.
module cache_port_arbiter #(
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  cache_port_arbiter_if.slave_ro  m0,
  cache_port_arbiter_if.slave     m1,
  cache_port_arbiter_if.master    c
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic any_req;
  logic rsp;
  logic last_eff;
  logic win;
  logic arb_en;

  assign any_req = m0.req | m1.req;
  assign rsp     = (state_q == WAIT) & c.rvalid;
  // The rvalid cycle arbitrates as if last were
  // already updated to the finishing owner.
  assign last_eff = rsp ? sel_q : last_q;

  // Pick the winner among current requesters (1 = M1).
  always_comb begin
    win = m1.req;
    if (m0.req && m1.req) begin
      if (ARB_MODE == 0) win = ~last_eff;
      else               win = (starve_q != LIMIT);
    end
  end

  // Next-state, winner capture and fairness state.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    arb_en   = 1'b0;
    unique case (state_q)
      IDLE: arb_en = any_req;
      ISSUE: begin
        if (c.gnt) state_d = WAIT;
      end
      WAIT: begin
        if (c.rvalid) begin
          last_d  = sel_q;
          arb_en  = any_req;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_en) begin
      state_d = ISSUE;
      sel_d   = win;
      if (win) begin
        addr_d  = m1.addr;
        we_d    = m1.we;
        be_d    = m1.be;
        wdata_d = m1.wdata;
        if (m0.req && starve_q != 4'hF)
          starve_d = starve_q + 4'd1;
      end else begin
        addr_d   = m0.addr;
        we_d     = 1'b0;
        be_d     = 4'hF;
        wdata_d  = 32'h0;
        starve_d = 4'd0;
      end
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      starve_q <= 4'd0;
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  assign c.req   = (state_q == ISSUE);
  assign c.addr  = addr_q;
  assign c.we    = we_q;
  assign c.be    = be_q;
  assign c.wdata = wdata_q;

  assign m0.gnt    = c.req & c.gnt & ~sel_q;
  assign m1.gnt    = c.req & c.gnt & sel_q;
  assign m0.rvalid = rsp & ~sel_q;
  assign m1.rvalid = rsp & sel_q;
  assign m0.rdata  = c.rdata;
  assign m1.rdata  = c.rdata;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed steps on two
// configurations, then random traffic against a model.
module tb_cache_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_port_arbiter_if ma0 ();
  cache_port_arbiter_if ma1 ();
  cache_port_arbiter_if ca ();
  cache_port_arbiter_if mb0 ();
  cache_port_arbiter_if mb1 ();
  cache_port_arbiter_if cb ();

  logic        r0_req, r1_req, r1_we, cg, cr;
  logic [31:0] r0_addr, r1_addr, r1_wdata, crd;
  logic [3:0]  r1_be;

  assign ma0.req = r0_req;   assign mb0.req = r0_req;
  assign ma0.addr = r0_addr; assign mb0.addr = r0_addr;
  assign ma0.we = 1'b0;      assign mb0.we = 1'b0;
  assign ma0.be = 4'h0;      assign mb0.be = 4'h0;
  assign ma0.wdata = 32'h0;  assign mb0.wdata = 32'h0;
  assign ma1.req = r1_req;   assign mb1.req = r1_req;
  assign ma1.addr = r1_addr; assign mb1.addr = r1_addr;
  assign ma1.we = r1_we;     assign mb1.we = r1_we;
  assign ma1.be = r1_be;     assign mb1.be = r1_be;
  assign ma1.wdata = r1_wdata;
  assign mb1.wdata = r1_wdata;
  assign ca.gnt = cg;        assign cb.gnt = cg;
  assign ca.rvalid = cr;     assign cb.rvalid = cr;
  assign ca.rdata = crd;     assign cb.rdata = crd;

  cache_port_arbiter #(.ARB_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .m0(ma0), .m1(ma1), .c(ca)
  );

  cache_port_arbiter #(
    .ARB_MODE(1), .STARVE_LIMIT(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .m0(mb0), .m1(mb1), .c(cb)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit expa [6] = '{0, 1, 0, 1, 0, 1};
  bit expb [6] = '{1, 1, 0, 1, 1, 0};

  int ng0, ng1, nr0, nr1;
  bit busy, pend, nx_creq, creq_now, rv;
  bit win, owner, mlast, g0s, g1s;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_we;
  logic [3:0]  ex_be;

  initial begin
    reset = 1'b1;
    r0_req = 0; r0_addr = 0;
    r1_req = 0; r1_addr = 0; r1_we = 0;
    r1_be = 0; r1_wdata = 0;
    cg = 0; cr = 0; crd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_creq", ca.req, 0);
    chk("rst_addr", ca.addr, 0);
    chk("rst_we", ca.we, 0);
    chk("rst_be", ca.be, 0);
    chk("rst_wdata", ca.wdata, 0);
    chk("rst_gnt", {ma0.gnt, ma1.gnt}, 0);
    chk("rst_rv", {ma0.rvalid, ma1.rvalid}, 0);
    chk("rst_b_creq", cb.req, 0);
    reset = 1'b0;

    r0_req = 1; r0_addr = 32'h100;
    @(negedge clk);
    chk("t1_idle_creq", ca.req, 0);
    step();
    @(negedge clk);
    chk("t1_creq", ca.req, 1);
    chk("t1_addr", ca.addr, 32'h100);
    chk("t1_we", ca.we, 0);
    chk("t1_be", ca.be, 4'hF);
    chk("t1_wdata", ca.wdata, 0);
    chk("t1_nogntyet", ma0.gnt, 0);
    step();
    cg = 1;
    @(negedge clk);
    chk("t1_g0", ma0.gnt, 1);
    chk("t1_g1", ma1.gnt, 0);
    chk("t1_b_g0", mb0.gnt, 1);
    step();
    cg = 0; r0_req = 0;
    @(negedge clk);
    chk("t1_wait_creq", ca.req, 0);
    step();
    cr = 1; crd = 32'hA5A5A5A5;
    @(negedge clk);
    chk("t1_rv0", ma0.rvalid, 1);
    chk("t1_rdata", ma0.rdata, 32'hA5A5A5A5);
    chk("t1_rv1", ma1.rvalid, 0);
    step();
    cr = 0;
    @(negedge clk);
    chk("t1_end_creq", ca.req, 0);
    chk("t1_end_rv0", ma0.rvalid, 0);

    r1_req = 1; r1_addr = 32'h204; r1_we = 1;
    r1_be = 4'b0011; r1_wdata = 32'h12345678;
    ng0 = 0; ng1 = 0; nr0 = 0; nr1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cg = (i == 1);
      cr = (i == 3);
      if (i == 2) r1_req = 0;
      @(negedge clk);
      if (i == 0) begin
        chk("t2_creq", ca.req, 1);
        chk("t2_addr", ca.addr, 32'h204);
        chk("t2_we", ca.we, 1);
        chk("t2_be", ca.be, 4'b0011);
        chk("t2_wdata", ca.wdata, 32'h12345678);
      end
      ng0 += int'(ma0.gnt); ng1 += int'(ma1.gnt);
      nr0 += int'(ma0.rvalid); nr1 += int'(ma1.rvalid);
    end
    chk("t2_ng1", ng1, 1);
    chk("t2_nr1", nr1, 1);
    chk("t2_m0", ng0 + nr0, 0);

    r0_req = 1; r0_addr = 32'h300;
    r1_req = 1; r1_addr = 32'h400; r1_we = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      cg = 1;
      @(negedge clk);
      chk("t3_creq", ca.req, 1);
      chk("t3_a_g0", ma0.gnt, !expa[i]);
      chk("t3_a_g1", ma1.gnt, expa[i]);
      chk("t3_b_g0", mb0.gnt, !expb[i]);
      chk("t3_b_g1", mb1.gnt, expb[i]);
      chk("t3_a_addr", ca.addr,
          expa[i] ? 32'h400 : 32'h300);
      step();
      cg = 0; cr = 1; crd = 32'(i);
      if (i == 5) begin r0_req = 0; r1_req = 0; end
      @(negedge clk);
      chk("t3_wait_creq", ca.req, 0);
      chk("t3_a_rv1", ma1.rvalid, expa[i]);
      chk("t3_b_rv1", mb1.rvalid, expb[i]);
      step();
      cr = 0;
    end

    cr = 1;
    @(negedge clk);
    chk("t4_idle_rv", {ma0.rvalid, ma1.rvalid}, 0);
    chk("t4_idle_creq", ca.req, 0);
    step();
    cr = 0; r1_req = 1; r1_addr = 32'h500;
    @(negedge clk);
    chk("t4_still_idle", ca.req, 0);
    step();
    cg = 1;
    @(negedge clk);
    chk("t4_g1", ma1.gnt, 1);
    step();
    r1_req = 0;
    @(negedge clk);
    chk("t4_wait_gnt", {ma0.gnt, ma1.gnt}, 0);
    chk("t4_wait_creq", ca.req, 0);
    step();
    cg = 0; cr = 1;
    @(negedge clk);
    chk("t4_rv1", ma1.rvalid, 1);
    chk("t4_rv0", ma0.rvalid, 0);
    step();
    cr = 0;

    r1_req = 1; r1_addr = 32'h600;
    step();
    cg = 1;
    @(negedge clk);
    chk("t5_g1", ma1.gnt, 1);
    step();
    cg = 0; r1_req = 0;
    @(negedge clk);
    chk("t5_wait", ca.req, 0);
    reset = 1; cg = 1; cr = 1;
    #1;
    chk("t5_creq", ca.req, 0);
    chk("t5_addr", ca.addr, 0);
    chk("t5_gnt", {ma0.gnt, ma1.gnt}, 0);
    chk("t5_rv", {ma0.rvalid, ma1.rvalid}, 0);
    step();
    reset = 0; cg = 0; cr = 0;
    r0_req = 1; r0_addr = 32'h700;
    r1_req = 1; r1_addr = 32'h800;
    step();
    cg = 1;
    @(negedge clk);
    chk("t5_tie_g0", ma0.gnt, 1);
    chk("t5_tie_g1", ma1.gnt, 0);
    chk("t5_tie_addr", ca.addr, 32'h700);
    step();
    cg = 0; r0_req = 0; r1_req = 0;
    reset = 1;
    step();
    reset = 0;

    mlast = 1; busy = 0; pend = 0; owner = 0;
    nx_creq = 0; g0s = 0; g1s = 0;
    ex_addr = 0; ex_we = 0; ex_be = 0; ex_wdata = 0;
    for (int k = 0; k < 3000; k++) begin
      if (g0s) r0_req = 0;
      if (!r0_req && $urandom_range(2) == 0) begin
        r0_req = 1; r0_addr = $urandom;
      end
      if (g1s) r1_req = 0;
      if (!r1_req && $urandom_range(2) == 0) begin
        r1_req = 1; r1_addr = $urandom;
        r1_we = ($urandom_range(1) == 1);
        r1_be = 4'($urandom);
        r1_wdata = $urandom;
      end
      cg = ca.req ? ($urandom_range(1) == 1)
                  : ($urandom_range(7) == 0);
      cr = pend ? ($urandom_range(1) == 1)
                : ($urandom_range(7) == 0);
      crd = $urandom;
      @(negedge clk);
      chk("r_creq", ca.req, nx_creq);
      if (nx_creq) begin
        chk("r_addr", ca.addr, ex_addr);
        chk("r_we", ca.we, ex_we);
        chk("r_be", ca.be, ex_be);
        chk("r_wdata", ca.wdata, ex_wdata);
      end
      chk("r_g0", ma0.gnt, nx_creq & cg & !owner);
      chk("r_g1", ma1.gnt, nx_creq & cg & owner);
      rv = pend & cr;
      chk("r_rv0", ma0.rvalid, rv & !owner);
      chk("r_rv1", ma1.rvalid, rv & owner);
      if (rv)
        chk("r_rdata",
            owner ? ma1.rdata : ma0.rdata, crd);
      g0s = ma0.gnt;
      g1s = ma1.gnt;
      creq_now = nx_creq;
      if (creq_now && cg) pend = 1;
      if (rv) begin
        pend = 0; busy = 0; mlast = owner;
      end
      if (!busy && (r0_req || r1_req)) begin
        win = (r0_req && r1_req) ? !mlast : r1_req;
        owner = win;
        busy = 1;
        nx_creq = 1;
        if (win) begin
          ex_addr = r1_addr; ex_we = r1_we;
          ex_be = r1_be; ex_wdata = r1_wdata;
        end else begin
          ex_addr = r0_addr; ex_we = 0;
          ex_be = 4'hF; ex_wdata = 0;
        end
      end else begin
        nx_creq = creq_now & !cg;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
